// File: rtl/qsn_shift_sched_85b.sv
// Control sequencer for the 85-bit quasi-cyclic shift network: reads a run of shift
// factors from the shift ROM and issues one left/right/merge configuration per cycle.
module qsn_shift_sched_85b #(
    parameter int Z        = 85,
    parameter int SEL_W    = 7,
    parameter int ADDR_W   = 10,
    parameter int LEN_W    = 6,
    parameter int PIPE_LAT = 2
) (
    input  logic              sys_clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  run_len,
    input  logic              stall,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [SEL_W-1:0]  rom_data,
    output logic [SEL_W-1:0]  left_sel,
    output logic [SEL_W-1:0]  right_sel,
    output logic [Z-2:0]      merge_sel,
    output logic              sel_valid,
    output logic              out_valid,
    output logic              busy,
    output logic              done,
    output logic              shift_err
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic                accept;
    logic                rd_vld_q;
    logic                sel_vld_q;
    logic [SEL_W-1:0]    lsel_q, rsel_q;
    logic [Z-2:0]        merge_q;
    logic                err_q;
    logic                pipe_busy;
    logic                inflight;

    logic                s_bad;
    logic [SEL_W-1:0]    s_eff;
    logic [SEL_W-1:0]    rsel_d;
    logic [Z-2:0]        merge_d;

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        rom_en  = 1'b0;
        done    = 1'b0;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && run_len != '0) begin
                    accept  = 1'b1;
                    addr_d  = base_addr;
                    len_d   = run_len;
                    cnt_d   = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (!stall) begin
                    rom_en = 1'b1;
                    addr_d = addr_q + ADDR_W'(1);
                    cnt_d  = cnt_q + LEN_W'(1);
                    if (cnt_q + LEN_W'(1) == len_q)
                        state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Every issued read has left the whole valid chain, so the
                // last out_valid was the previous cycle.
                if (!inflight) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Out-of-range factors are issued as a zero shift and flagged.
    assign s_bad  = (int'(rom_data) >= Z);
    assign s_eff  = s_bad ? '0 : rom_data;
    assign rsel_d = (s_eff == '0) ? '0 : SEL_W'(Z - int'(s_eff));

    always_comb begin
        merge_d = '0;
        for (int j = 0; j < Z-1; j++)
            merge_d[j] = (s_eff != '0) && (j < Z - int'(s_eff));
    end

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            rd_vld_q  <= 1'b0;
            sel_vld_q <= 1'b0;
            lsel_q    <= '0;
            rsel_q    <= '0;
            merge_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            rd_vld_q  <= rom_en;
            sel_vld_q <= rd_vld_q;
            if (accept)
                err_q <= 1'b0;
            if (rd_vld_q) begin
                lsel_q  <= s_eff;
                rsel_q  <= rsel_d;
                merge_q <= merge_d;
                if (s_bad)
                    err_q <= 1'b1;
            end
        end
    end

    // Mirrors the network's output registers; never stalls.
    generate
        if (PIPE_LAT == 0) begin : g_comb
            assign out_valid = sel_vld_q;
            assign pipe_busy = 1'b0;
        end else begin : g_pipe
            logic [PIPE_LAT-1:0] vld_pipe_q;
            always_ff @(posedge sys_clk) begin
                if (!rstn)
                    vld_pipe_q <= '0;
                else
                    vld_pipe_q <= PIPE_LAT'({vld_pipe_q, sel_vld_q});
            end
            assign out_valid = vld_pipe_q[PIPE_LAT-1];
            assign pipe_busy = |vld_pipe_q;
        end
    endgenerate

    assign inflight  = rd_vld_q | sel_vld_q | pipe_busy;
    assign rom_addr  = addr_q;
    assign left_sel  = lsel_q;
    assign right_sel = rsel_q;
    assign merge_sel = merge_q;
    assign sel_valid = sel_vld_q;
    assign busy      = (state_q != IDLE);
    assign shift_err = err_q;

endmodule

// File: tb/tb_qsn_shift_sched_85b.sv
// Scoreboard bench for qsn_shift_sched_85b: expected ROM reads, selects, out_valid and done
// are planned from a run-level model and checked by an independent monitor.
module tb_qsn_shift_sched_85b;
    localparam int Z = 85, SEL_W = 7, ADDR_W = 10, LEN_W = 6, PL = 2;

    logic              sys_clk = 1'b0;
    logic              rstn = 1'b0, start = 1'b0, stall = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [LEN_W-1:0]  run_len = '0;
    logic [SEL_W-1:0]  rom_data = '0;
    logic              rom_en, sel_valid, out_valid, busy, done, shift_err;
    logic [ADDR_W-1:0] rom_addr;
    logic [SEL_W-1:0]  left_sel, right_sel;
    logic [Z-2:0]      merge_sel;

    qsn_shift_sched_85b #(.Z(Z), .SEL_W(SEL_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .PIPE_LAT(PL)) dut (
        .sys_clk(sys_clk), .rstn(rstn), .start(start), .base_addr(base_addr), .run_len(run_len),
        .stall(stall), .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .left_sel(left_sel), .right_sel(right_sel), .merge_sel(merge_sel), .sel_valid(sel_valid),
        .out_valid(out_valid), .busy(busy), .done(done), .shift_err(shift_err));

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    logic [SEL_W-1:0] rom_mem [0:1023];
    always @(posedge sys_clk) if (rom_en === 1'b1) rom_data <= rom_mem[rom_addr];

    typedef struct { int rel; logic [ADDR_W-1:0] addr; } rd_t;
    typedef struct { int rel; logic [SEL_W-1:0] l; logic [SEL_W-1:0] r; logic [Z-2:0] m; logic err; } sel_t;
    rd_t  rd_q[$];
    sel_t sel_q[$];
    int   out_q[$];
    int   done_q[$];

    int   n_chk = 0, n_fail = 0;
    int   t_start = 0;
    bit   mon_en = 1'b0;
    bit   stall_pat [0:511];
    logic sticky_err = 1'b0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: asserted with nothing outstanding (cycle %0d)", nm, cyc);
    endtask

    // Monitor: pops and compares whenever the DUT presents an event.
    int   mrel;
    rd_t  mrd;
    sel_t msel;
    int   mint;
    always @(negedge sys_clk) begin
        if (mon_en) begin
            mrel = cyc - t_start + 1;
            if (rom_en === 1'b1) begin
                if (rd_q.size() == 0) unexpected("rom_en");
                else begin
                    mrd = rd_q.pop_front();
                    check("rom_en time", mrel, mrd.rel);
                    check("rom_addr", rom_addr, mrd.addr);
                end
            end
            if (sel_valid === 1'b1) begin
                if (sel_q.size() == 0) unexpected("sel_valid");
                else begin
                    msel = sel_q.pop_front();
                    check("sel_valid time", mrel, msel.rel);
                    check("left_sel", left_sel, msel.l);
                    check("right_sel", right_sel, msel.r);
                    check("merge_sel", merge_sel, msel.m);
                    check("shift_err at sel", shift_err, msel.err);
                end
            end
            if (out_valid === 1'b1) begin
                if (out_q.size() == 0) unexpected("out_valid");
                else begin
                    mint = out_q.pop_front();
                    check("out_valid time", mrel, mint);
                end
            end
            if (done === 1'b1) begin
                if (done_q.size() == 0) unexpected("done");
                else begin
                    mint = done_q.pop_front();
                    check("done time", mrel, mint);
                    check("busy at done", busy, 1'b1);
                end
            end
        end
    end

    // Run-level reference: issue slots are the first len unstalled cycles from T+1.
    task automatic plan_run(input logic [ADDR_W-1:0] base, input int len);
        int r, n;
        logic err;
        logic [ADDR_W-1:0] a;
        int s;
        logic [Z-1:0] t;
        rd_t  er;
        sel_t es;
        r = 1; n = 0; err = 1'b0;
        while (n < len) begin
            if (!stall_pat[r]) begin
                a = ADDR_W'(int'(base) + n);
                s = int'(rom_mem[a]);
                if (s >= Z) begin err = 1'b1; s = 0; end
                er.rel = r; er.addr = a;
                rd_q.push_back(er);
                es.rel = r + 2;
                es.l = SEL_W'(s);
                es.r = SEL_W'((Z - s) % Z);
                if (s == 0) es.m = '0;
                else begin
                    t = (Z'(1) << (Z - s)) - Z'(1);
                    es.m = t[Z-2:0];
                end
                es.err = err;
                sel_q.push_back(es);
                out_q.push_back(r + 2 + PL);
                n++;
                if (n == len) done_q.push_back(r + 2 + PL + 1);
            end
            r++;
        end
        sticky_err = err;
    endtask

    task automatic clear_queues();
        rd_q.delete(); sel_q.delete(); out_q.delete(); done_q.delete();
    endtask

    task automatic do_run(input logic [ADDR_W-1:0] base, input int len, input bit spurious);
        plan_run(base, len);
        base_addr = base; run_len = LEN_W'(len); start = 1'b1;
        @(posedge sys_clk); #1;
        t_start = cyc;
        start = 1'b0;
        for (int k = 1; k < 512; k++) begin
            stall = stall_pat[k];
            if (spurious && k == 2) begin
                start = 1'b1;
                base_addr = ADDR_W'($urandom);
                run_len = LEN_W'($urandom_range(1, 63));
            end else start = 1'b0;
            if (k == 1) check("busy after start", busy, 1'b1);
            @(posedge sys_clk); #1;
            if (rd_q.size() == 0 && sel_q.size() == 0 && out_q.size() == 0 && done_q.size() == 0) break;
            if (k >= 400) begin
                n_chk++; n_fail++;
                $display("FAIL run timeout: %0d events outstanding, expected 0", rd_q.size() + sel_q.size() + out_q.size() + done_q.size());
                clear_queues();
                break;
            end
        end
        stall = 1'b0; start = 1'b0;
        check("busy after done", busy, 1'b0);
        check("shift_err after run", shift_err, sticky_err);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " rom_en"}, rom_en, 1'b0);
        check({tag, " rom_addr"}, rom_addr, 0);
        check({tag, " left_sel"}, left_sel, 0);
        check({tag, " right_sel"}, right_sel, 0);
        check({tag, " merge_sel"}, merge_sel, 0);
        check({tag, " sel_valid"}, sel_valid, 1'b0);
        check({tag, " out_valid"}, out_valid, 1'b0);
        check({tag, " busy"}, busy, 1'b0);
        check({tag, " done"}, done, 1'b0);
        check({tag, " shift_err"}, shift_err, 1'b0);
    endtask

    task automatic clear_stall();
        for (int i = 0; i < 512; i++) stall_pat[i] = 1'b0;
    endtask

    initial begin
        rd_t er;
        for (int i = 0; i < 1024; i++) rom_mem[i] = SEL_W'($urandom_range(0, 99));
        rom_mem[10'h010] = 7'd0;  rom_mem[10'h011] = 7'd1;  rom_mem[10'h012] = 7'd84;
        rom_mem[10'h200] = 7'd90; rom_mem[10'h201] = 7'd5;
        rom_mem[10'h3FF] = 7'd17; rom_mem[10'h000] = 7'd42;
        clear_stall();

        // Reset state
        rstn = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        check_zero("reset");
        rstn = 1'b1;
        mon_en = 1'b1;
        @(posedge sys_clk); #1;

        // Directed run {0,1,84}, then again with a one-cycle stall at T+2
        do_run(10'h010, 3, 1'b0);
        stall_pat[2] = 1'b1;
        do_run(10'h010, 3, 1'b0);
        clear_stall();

        // Out-of-range factor, sticky error while idle
        do_run(10'h200, 2, 1'b0);
        repeat (3) begin
            check("shift_err idle sticky", shift_err, 1'b1);
            @(posedge sys_clk); #1;
        end

        // start with run_len=0 in IDLE is ignored
        base_addr = 10'h005; run_len = '0; start = 1'b1;
        @(posedge sys_clk); #1;
        start = 1'b0;
        repeat (4) begin
            check("len0 busy", busy, 1'b0);
            check("len0 rom_en", rom_en, 1'b0);
            check("len0 shift_err kept", shift_err, 1'b1);
            @(posedge sys_clk); #1;
        end

        // Reset in the middle of FETCH flushes everything
        er.rel = 1; er.addr = 10'h010; rd_q.push_back(er);
        er.rel = 2; er.addr = 10'h011; rd_q.push_back(er);
        base_addr = 10'h010; run_len = 6'd3; start = 1'b1;
        @(posedge sys_clk); #1;
        t_start = cyc; start = 1'b0;
        @(posedge sys_clk); #1;
        rstn = 1'b0;
        @(posedge sys_clk); #1;
        rstn = 1'b1;
        check("reset reads outstanding", rd_q.size(), 0);
        clear_queues();
        @(negedge sys_clk);
        check_zero("midreset");
        repeat (8) @(posedge sys_clk);
        #1;
        sticky_err = 1'b0;

        // Address wrap, and a start pulse held during FETCH
        do_run(10'h3FF, 2, 1'b0);
        do_run(10'h010, 3, 1'b1);

        // Randomized runs with random stall patterns
        for (int n = 0; n < 25; n++) begin
            clear_stall();
            for (int k = 1; k < 200; k++) stall_pat[k] = ($urandom_range(0, 3) == 0);
            do_run(ADDR_W'($urandom), $urandom_range(1, 20), bit'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) begin
                @(posedge sys_clk); #1;
            end
        end

        repeat (4) @(posedge sys_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
